divremsqrt_intpostproc: RTL and testbench

- Integer post-processing stage for the shared FP/integer divide-remainder unit.
- Accepts the raw quotient, final residual and divisor from the digit-recurrence iterator, plus the operand metadata captured at preprocessing (signs, zero flags, normalization shift, W64).
- Corrects a negative residual, de-normalizes, applies signs and special cases, and holds an XLEN-bit result for writeback.
- Valid/ready handshake on both sides; sits between the iterator and the M/W integer result mux.

---
 rtl/divremsqrt_intpostproc_if.sv | 37 +++
 rtl/divremsqrt_intpostproc.sv | 162 ++++++++++++++++
 tb/tb_divremsqrt_intpostproc.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/divremsqrt_intpostproc_if.sv
// Handshake and data bundle between the divide iterator, the integer
// post-processing stage and the integer result mux.
interface divremsqrt_intpostproc_if #(
  parameter int XLEN    = 64,
  parameter int DIVb    = 64,
  parameter int DIVBLEN = 7
);
  logic               InValid;
  logic               InReady;
  logic [DIVb:0]      QIn;
  logic [DIVb+3:0]    WIn;
  logic [DIVb+3:0]    DIn;
  logic [DIVBLEN-1:0] NormShiftIn;
  logic               RemOpIn;
  logic               AsIn;
  logic               BsIn;
  logic               ALTBIn;
  logic               BZeroIn;
  logic               W64In;
  logic [XLEN-1:0]    AIn;
  logic               OutValid;
  logic               OutReady;
  logic [XLEN-1:0]    Result;
  logic               Busy;

  modport master (
    output InValid, QIn, WIn, DIn, NormShiftIn, RemOpIn, AsIn, BsIn,
           ALTBIn, BZeroIn, W64In, AIn, OutReady,
    input  InReady, OutValid, Result, Busy
  );

  modport slave (
    input  InValid, QIn, WIn, DIn, NormShiftIn, RemOpIn, AsIn, BsIn,
           ALTBIn, BZeroIn, W64In, AIn, OutReady,
    output InReady, OutValid, Result, Busy
  );
endinterface

// File: rtl/divremsqrt_intpostproc.sv
// Integer post-processing for the divide/remainder unit: residual fix-up,
// de-normalization, sign/special-case handling. DIVREM_W64_EN enables W64 sign-extension.
module divremsqrt_intpostproc #(
  parameter int XLEN    = 64,
  parameter int DIVb    = 64,
  parameter int DIVBLEN = 7
) (
  input  logic                     clk,
  input  logic                     reset_n,
  divremsqrt_intpostproc_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FIX  = 3'd1,
    S_NORM = 3'd2,
    S_SIGN = 3'd3,
    S_HOLD = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [DIVb:0]      r_q;
  logic [DIVb+3:0]    r_w;
  logic [DIVb+3:0]    r_d;
  logic [DIVBLEN-1:0] r_shift;
  logic               r_remop;
  logic               r_as;
  logic               r_bs;
  logic               r_altb;
  logic               r_bzero;
  logic [XLEN-1:0]    r_a;
  logic [XLEN-1:0]    r_norm;
  logic [XLEN-1:0]    r_result;
`ifdef DIVREM_W64_EN
  logic               r_w64;
`else
  logic               w_unused_w64;
`endif

  logic               w_xfer;
  logic               w_negate;
  logic [DIVb:0]      w_sel;
  logic [XLEN-1:0]    w_final;
  logic [XLEN-1:0]    w_result;

  assign w_xfer = bus.InValid & (r_state == S_IDLE);
  assign w_sel  = r_remop ? r_w[DIVb:0] : r_q;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_xfer) w_next = S_FIX;
        else        w_next = S_IDLE;
      end
      S_FIX:  w_next = S_NORM;
      S_NORM: w_next = S_SIGN;
      S_SIGN: w_next = S_HOLD;
      S_HOLD: begin
        if (bus.OutReady) w_next = S_IDLE;
        else              w_next = S_HOLD;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    bus.InReady  = (r_state == S_IDLE);
    bus.Busy     = (r_state != S_IDLE);
    bus.OutValid = (r_state == S_HOLD);
  end

  assign bus.Result = r_result;

  // Sign and special-case selection; the overflow case needs no extra term
  always_comb begin
    w_negate = r_remop ? r_as : (r_as ^ r_bs);
    if (r_bzero) begin
      w_final = r_remop ? r_a : {XLEN{1'b1}};
    end else if (r_altb) begin
      w_final = r_remop ? r_a : {XLEN{1'b0}};
    end else if (w_negate) begin
      w_final = {XLEN{1'b0}} - r_norm;
    end else begin
      w_final = r_norm;
    end
  end

`ifdef DIVREM_W64_EN
  // Word-op sign extension of the low 32 bits
  always_comb begin
    if (r_w64) w_result = XLEN'(signed'(w_final[31:0]));
    else       w_result = w_final;
  end
`else
  assign w_result     = w_final;
  assign w_unused_w64 = bus.W64In;
`endif

  // Datapath: capture, residual fix-up, de-normalization, final result
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_q      <= {(DIVb+1){1'b0}};
      r_w      <= {(DIVb+4){1'b0}};
      r_d      <= {(DIVb+4){1'b0}};
      r_shift  <= {DIVBLEN{1'b0}};
      r_remop  <= 1'b0;
      r_as     <= 1'b0;
      r_bs     <= 1'b0;
      r_altb   <= 1'b0;
      r_bzero  <= 1'b0;
      r_a      <= {XLEN{1'b0}};
      r_norm   <= {XLEN{1'b0}};
      r_result <= {XLEN{1'b0}};
`ifdef DIVREM_W64_EN
      r_w64    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            r_q     <= bus.QIn;
            r_w     <= bus.WIn;
            r_d     <= bus.DIn;
            r_shift <= bus.NormShiftIn;
            r_remop <= bus.RemOpIn;
            r_as    <= bus.AsIn;
            r_bs    <= bus.BsIn;
            r_altb  <= bus.ALTBIn;
            r_bzero <= bus.BZeroIn;
            r_a     <= bus.AIn;
`ifdef DIVREM_W64_EN
            r_w64   <= bus.W64In;
`endif
          end
        end
        S_FIX: begin
          if (r_w[DIVb+3]) begin
            r_w <= r_w + r_d;
            r_q <= r_q - {{DIVb{1'b0}}, 1'b1};
          end
        end
        S_NORM:  r_norm   <= XLEN'(w_sel >> r_shift);
        S_SIGN:  r_result <= w_result;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divremsqrt_intpostproc.sv
// Directed self-checking bench for divremsqrt_intpostproc.
module tb_divremsqrt_intpostproc;
  localparam int XLEN    = 64;
  localparam int DIVb    = 64;
  localparam int DIVBLEN = 7;

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_errors = 0;

  divremsqrt_intpostproc_if #(.XLEN(XLEN), .DIVb(DIVb), .DIVBLEN(DIVBLEN)) bus ();

  divremsqrt_intpostproc #(.XLEN(XLEN), .DIVb(DIVb), .DIVBLEN(DIVBLEN)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [64:0] q, input logic [67:0] w, input logic [67:0] d,
                      input logic [6:0] sh, input logic rem, input logic as_i,
                      input logic bs_i, input logic altb, input logic bz,
                      input logic w64, input logic [63:0] a);
    bus.QIn = q; bus.WIn = w; bus.DIn = d; bus.NormShiftIn = sh;
    bus.RemOpIn = rem; bus.AsIn = as_i; bus.BsIn = bs_i;
    bus.ALTBIn = altb; bus.BZeroIn = bz; bus.W64In = w64; bus.AIn = a;
  endtask

  // Transfer the loaded operands, wait for OutValid, check latency and result.
  task automatic run(input string tag, input logic [63:0] exp);
    int cnt;
    bus.InValid = 1'b1;
    tick();
    bus.InValid = 1'b0;
    cnt = 0;
    while (bus.OutValid !== 1'b1 && cnt < 10) begin
      tick();
      cnt++;
    end
    check({tag, "_lat"}, 64'(cnt), 64'd3);
    check(tag, bus.Result, exp);
    tick();
  endtask

  logic [67:0] w_pos2, w_neg5, d7;
  logic [63:0] exp_w64;

  initial begin
    w_pos2 = 68'd2 << 51;
    w_neg5 = 68'd0 - (68'd5 << 51);
    d7     = 68'd7 << 51;
`ifdef DIVREM_W64_EN
    exp_w64 = 64'hFFFF_FFFF_8000_0000;
`else
    exp_w64 = 64'h0000_0000_8000_0000;
`endif

    reset_n = 1'b0;
    bus.InValid = 1'b0;
    bus.OutReady = 1'b1;
    load(65'd0, 68'd0, 68'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    tick();
    tick();
    check("rst_inready", 64'(bus.InReady), 64'd1);
    check("rst_outvalid", 64'(bus.OutValid), 64'd0);
    check("rst_result", bus.Result, 64'd0);
    check("rst_busy", 64'(bus.Busy), 64'd0);
    reset_n = 1'b1;
    tick();

    // Unsigned 100/7
    load(65'd14 << 51, w_pos2, d7, 7'd51, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd100);
    run("udiv_q", 64'd14);
    bus.RemOpIn = 1'b1;
    run("udiv_r", 64'd2);

    // Negative residual correction
    load(65'd15 << 51, w_neg5, d7, 7'd51, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd100);
    run("fix_q", 64'd14);
    bus.RemOpIn = 1'b1;
    run("fix_r", 64'd2);

    // Signed -100/7
    load(65'd14 << 51, w_pos2, d7, 7'd51, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C);
    run("sdiv_q", 64'hFFFF_FFFF_FFFF_FFF2);
    bus.RemOpIn = 1'b1;
    run("sdiv_r", 64'hFFFF_FFFF_FFFF_FFFE);

    // Special cases
    load(65'd0, 68'd0, d7, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h1234);
    run("bzero_q", 64'hFFFF_FFFF_FFFF_FFFF);
    bus.RemOpIn = 1'b1;
    run("bzero_r", 64'h1234);
    load(65'd0, 68'd5 << 51, d7, 7'd51, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'd5);
    run("altb_q", 64'd0);
    bus.RemOpIn = 1'b1;
    run("altb_r", 64'd5);

    // W64 word op
    load(65'h8000_0000 << 20, 68'd0, d7, 7'd20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'd0);
    run("w64_q", exp_w64);

    // Shift boundaries
    load({65{1'b1}}, 68'd0, d7, 7'd64, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    run("shift64", 64'd1);
    bus.NormShiftIn = 7'd65;
    run("shift65", 64'd0);
    bus.NormShiftIn = 7'd127;
    run("shift127", 64'd0);

    // Signed overflow: most-negative / -1
    load(65'd1 << 63, 68'd0, 68'd1 << 64, 7'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h8000_0000_0000_0000);
    run("ovf_q", 64'h8000_0000_0000_0000);
    bus.RemOpIn = 1'b1;
    run("ovf_r", 64'd0);

    // Back-pressure, ignored InValid while busy
    load(65'd14 << 51, w_pos2, d7, 7'd51, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd100);
    bus.OutReady = 1'b0;
    bus.InValid = 1'b1;
    tick();
    check("bp_inready_fix", 64'(bus.InReady), 64'd0);
    check("bp_busy_fix", 64'(bus.Busy), 64'd1);
    bus.QIn = 65'd99 << 51;
    tick();
    tick();
    check("bp_outvalid_sign", 64'(bus.OutValid), 64'd0);
    tick();
    for (int i = 0; i < 10; i++) begin
      check("bp_outvalid", 64'(bus.OutValid), 64'd1);
      check("bp_result", bus.Result, 64'd14);
      check("bp_inready", 64'(bus.InReady), 64'd0);
      tick();
    end
    bus.InValid = 1'b0;
    bus.OutReady = 1'b1;
    check("bp_last_outvalid", 64'(bus.OutValid), 64'd1);
    tick();
    check("bp_release_outvalid", 64'(bus.OutValid), 64'd0);
    check("bp_release_inready", 64'(bus.InReady), 64'd1);

    // Reset while in NORM abandons the operation
    bus.InValid = 1'b1;
    tick();
    bus.InValid = 1'b0;
    tick();
    check("mid_busy_norm", 64'(bus.Busy), 64'd1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("mid_outvalid", 64'(bus.OutValid), 64'd0);
    check("mid_result", bus.Result, 64'd0);
    check("mid_inready", 64'(bus.InReady), 64'd1);
    check("mid_busy", 64'(bus.Busy), 64'd0);
    for (int i = 0; i < 6; i++) tick();
    check("mid_no_deliver", 64'(bus.OutValid), 64'd0);

    // InValid together with reset: reset wins
    reset_n = 1'b0;
    bus.InValid = 1'b1;
    tick();
    reset_n = 1'b1;
    bus.InValid = 1'b0;
    check("rstvalid_inready", 64'(bus.InReady), 64'd1);
    tick();
    check("rstvalid_busy", 64'(bus.Busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
